// File: rtl/cp0_exception_unit_if.sv
// CP0 access, exception request and PC hand-off signals between the core datapath and CP0.
// The datapath drives the master side; the CP0 exception unit uses the slave side.
interface cp0_exception_unit_if;
    logic [31:0] PresentPC;
    logic        CP0Write;
    logic [4:0]  CP0Addr;
    logic [31:0] CP0WData;
    logic [31:0] CP0RData;
    logic        IsEret;
    logic        IsSyscall;
    logic [5:0]  HwInt;
    logic        HasExp;
    logic [31:0] EPC;

    modport master (
        output PresentPC, CP0Write, CP0Addr, CP0WData, IsEret, IsSyscall, HwInt,
        input  CP0RData, HasExp, EPC
    );

    modport slave (
        input  PresentPC, CP0Write, CP0Addr, CP0WData, IsEret, IsSyscall, HwInt,
        output CP0RData, HasExp, EPC
    );
endinterface

// File: rtl/cp0_exception_unit.sv
// CP0 register file (SR, Cause, EPC, PRId) and exception controller; HasExp/CP0RData are
// combinational, all state updates on the rising clk edge; HwInt passes a SYNC_STAGES flop chain.
module cp0_exception_unit #(
    parameter logic [31:0] PRID_VALUE  = 32'h0001_8000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cp0_exception_unit_if.slave   cp0
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;
    localparam logic [4:0] EXC_INT    = 5'd0;
    localparam logic [4:0] EXC_SYS    = 5'd8;

    logic [SYNC_STAGES-1:0][5:0] sync_q;
    logic [5:0]  ip;

    logic [5:0]  im_q,      im_d;
    logic        exl_q,     exl_d;
    logic        ie_q,      ie_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [31:0] epc_q,     epc_d;

    logic int_req, sys_req, has_exp, wr_sr, wr_epc;

    // Stage 0 samples the raw asynchronous level; the last stage is Cause.IP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], cp0.HwInt};
        end
    end

    assign ip      = sync_q[SYNC_STAGES-1];
    assign int_req = ie_q & ~exl_q & (|(ip & im_q));
    assign sys_req = cp0.IsSyscall & ~exl_q;
    assign has_exp = int_req | sys_req;
    assign wr_sr   = cp0.CP0Write && (cp0.CP0Addr == ADDR_SR);
    assign wr_epc  = cp0.CP0Write && (cp0.CP0Addr == ADDR_EPC);

    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        if (has_exp) begin
            // Entry squashes any eret or mtc0 issued by the same instruction slot.
            epc_d     = cp0.PresentPC;
            exl_d     = 1'b1;
            exccode_d = int_req ? EXC_INT : EXC_SYS;
        end else begin
            if (wr_epc) begin
                epc_d = cp0.CP0WData;
            end
            if (wr_sr) begin
                im_d  = cp0.CP0WData[15:10];
                exl_d = cp0.CP0WData[1] & ~cp0.IsEret;
                ie_d  = cp0.CP0WData[0];
            end else if (cp0.IsEret) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            im_q      <= '0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            exccode_q <= '0;
            epc_q     <= '0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

    always_comb begin
        case (cp0.CP0Addr)
            ADDR_SR:    cp0.CP0RData = {16'b0, im_q, 8'b0, exl_q, ie_q};
            ADDR_CAUSE: cp0.CP0RData = {16'b0, ip, 3'b0, exccode_q, 2'b0};
            ADDR_EPC:   cp0.CP0RData = epc_q;
            ADDR_PRID:  cp0.CP0RData = PRID_VALUE;
            default:    cp0.CP0RData = 32'b0;
        endcase
    end

    assign cp0.HasExp = has_exp;
    assign cp0.EPC    = epc_q;

endmodule
